// File: rtl/byte_unstrip.sv
// byte_unstrip
//   Receive-side lane de-striper. Accepts one parallel word per handshake
//   (one byte plus K flag per lane) and re-serializes it into a single byte
//   stream, lane 0 first. SKP/IDL filler symbols are dropped. Packet framing
//   (STP/SDP ... END/EDB) is tracked, and lane-placement or sequence
//   violations are flagged.
//
// Ports
//   CLK        rising-edge clock
//   RESET_L    asynchronous active-low reset
//   IN_VALID   parallel word present
//   IN_READY   block can accept a word this cycle (holding register empty)
//   LANE_DATA  lane i byte = bits [8i+7:8i]
//   LANE_K     bit i = lane i byte is a control (K) symbol
//   D / DK     serialized byte and its K flag
//   OUT_VALID  D/DK hold a forwarded byte this cycle
//   FRAME_ERR  one-cycle pulse, framing violation on the byte on D
//   IN_PKT     framing state after the byte on D (1 = inside packet)

module byte_unstrip #(
    parameter int LANES = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_L,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [8*LANES-1:0]   LANE_DATA,
    input  logic [LANES-1:0]     LANE_K,
    output logic [7:0]           D,
    output logic                 DK,
    output logic                 OUT_VALID,
    output logic                 FRAME_ERR,
    output logic                 IN_PKT
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Serializer (active word + lane index) and one-word holding register
    logic [8*LANES-1:0] ser_data_reg;
    logic [LANES-1:0]   ser_k_reg;
    logic               ser_busy_reg;
    logic [IW-1:0]      idx_reg;
    logic [8*LANES-1:0] hold_data_reg;
    logic [LANES-1:0]   hold_k_reg;
    logic               hold_valid_reg;

    logic [7:0]         d_reg;
    logic               dk_reg;
    logic               out_valid_reg;
    logic               frame_err_reg;

    logic [7:0]         lane_byte [LANES];
    logic [7:0]         cur_byte;
    logic               cur_k;
    logic               is_filler;
    logic               err_next;
    logic               accept;
    logic               load_slot;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_byte[gi] = ser_data_reg[8*gi +: 8];
        end
    endgenerate

    assign cur_byte  = lane_byte[idx_reg];
    assign cur_k     = ser_k_reg[idx_reg];
    assign is_filler = cur_k && ((cur_byte == SYM_SKP) || (cur_byte == SYM_IDL));

    assign IN_READY  = ~hold_valid_reg;
    assign accept    = IN_VALID & ~hold_valid_reg;
    // The serializer can take a new word when idle or when finishing its last lane
    assign load_slot = ~ser_busy_reg | (idx_reg == LAST_IDX);

    // Framing FSM: state register
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Framing FSM: next state and error, evaluated on each forwarded byte
    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        if (ser_busy_reg && !is_filler) begin
            if (cur_k) begin
                if ((cur_byte == SYM_STP) || (cur_byte == SYM_SDP)) begin
                    // Start is still honoured even when misplaced
                    state_next = PKT;
                    err_next   = (state_reg == PKT) || (idx_reg != '0);
                end else if ((cur_byte == SYM_END) || (cur_byte == SYM_EDB)) begin
                    state_next = IDLE;
                    err_next   = (state_reg == IDLE) || (idx_reg != LAST_IDX);
                end
            end else begin
                // Data outside a packet
                err_next = (state_reg == IDLE);
            end
        end
    end

    // Serializer, holding register and output registers
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            ser_data_reg   <= '0;
            ser_k_reg      <= '0;
            ser_busy_reg   <= 1'b0;
            idx_reg        <= '0;
            hold_data_reg  <= '0;
            hold_k_reg     <= '0;
            hold_valid_reg <= 1'b0;
            d_reg          <= '0;
            dk_reg         <= 1'b0;
            out_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (load_slot) begin
                idx_reg <= '0;
                if (hold_valid_reg) begin
                    ser_data_reg   <= hold_data_reg;
                    ser_k_reg      <= hold_k_reg;
                    ser_busy_reg   <= 1'b1;
                    hold_valid_reg <= 1'b0;
                end else if (accept) begin
                    // Holding register bypassed: word goes straight in
                    ser_data_reg <= LANE_DATA;
                    ser_k_reg    <= LANE_K;
                    ser_busy_reg <= 1'b1;
                end else begin
                    ser_busy_reg <= 1'b0;
                end
            end else begin
                idx_reg <= idx_reg + IW'(1);
                if (accept) begin
                    hold_data_reg  <= LANE_DATA;
                    hold_k_reg     <= LANE_K;
                    hold_valid_reg <= 1'b1;
                end
            end

            if (ser_busy_reg && !is_filler) begin
                d_reg         <= cur_byte;
                dk_reg        <= cur_k;
                out_valid_reg <= 1'b1;
                frame_err_reg <= err_next;
            end else begin
                // Filler or idle: D/DK keep their last forwarded value
                out_valid_reg <= 1'b0;
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign D         = d_reg;
    assign DK        = dk_reg;
    assign OUT_VALID = out_valid_reg;
    assign FRAME_ERR = frame_err_reg;
    assign IN_PKT    = (state_reg == PKT);

endmodule

// File: tb/tb_byte_unstrip.sv
// tb_byte_unstrip
//   Self-checking bench for byte_unstrip (LANES=4). Each accepted word is
//   expanded by a reference model into per-cycle expected output events,
//   scheduled back-to-back behind earlier words; every cycle the DUT outputs
//   and IN_READY are compared against that schedule.

module tb_byte_unstrip;

    localparam int LANES = 4;

    logic                 CLK = 1'b0;
    logic                 RESET_L;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [8*LANES-1:0]   LANE_DATA;
    logic [LANES-1:0]     LANE_K;
    logic [7:0]           D;
    logic                 DK;
    logic                 OUT_VALID;
    logic                 FRAME_ERR;
    logic                 IN_PKT;

    byte_unstrip #(.LANES(LANES)) dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .LANE_DATA (LANE_DATA),
        .LANE_K    (LANE_K),
        .D         (D),
        .DK        (DK),
        .OUT_VALID (OUT_VALID),
        .FRAME_ERR (FRAME_ERR),
        .IN_PKT    (IN_PKT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         fill;
        logic [7:0] d;
        logic       k;
        logic       err;
        logic       pkt;
    } ev_t;

    ev_t        exp_tab [int];
    int         cyc;
    int         last_end;
    int         last_start;
    bit         m_pkt;
    logic [7:0] last_d;
    logic       last_dk;
    logic       last_pkt;
    int         n_compared;
    int         n_mismatched;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic void model_reset();
        exp_tab.delete();
        last_end   = 0;
        last_start = 0;
        m_pkt      = 1'b0;
        last_d     = 8'h00;
        last_dk    = 1'b0;
        last_pkt   = 1'b0;
    endfunction

    // Word accepted at edge cyc: its lanes occupy consecutive edges starting
    // one edge later, or right after the previous word's last lane.
    function automatic void schedule(input logic [8*LANES-1:0] data, input logic [LANES-1:0] k);
        int   start;
        ev_t  e;
        logic [7:0] b;
        logic kk;
        start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        for (int l = 0; l < LANES; l++) begin
            b      = data[8*l +: 8];
            kk     = k[l];
            e.fill = kk && (b == 8'h1C || b == 8'h7C);
            e.d    = b;
            e.k    = kk;
            e.err  = 1'b0;
            if (!e.fill) begin
                if (kk) begin
                    if (b == 8'hFB || b == 8'h5C) begin
                        e.err = m_pkt || (l != 0);
                        m_pkt = 1'b1;
                    end else if (b == 8'hFD || b == 8'hFE) begin
                        e.err = !m_pkt || (l != LANES - 1);
                        m_pkt = 1'b0;
                    end
                end else begin
                    e.err = !m_pkt;
                end
            end
            e.pkt = m_pkt;
            exp_tab[start + l] = e;
        end
        last_start = start;
        last_end   = start + LANES - 1;
        $display("accept word %08h k=%b at cycle %0d, lanes out cycles %0d..%0d",
                 data, k, cyc, start, last_end);
    endfunction

    task automatic check_cycle();
        logic exp_ov;
        logic exp_err;
        ev_t  e;
        exp_ov  = 1'b0;
        exp_err = 1'b0;
        if (exp_tab.exists(cyc)) begin
            e = exp_tab[cyc];
            exp_tab.delete(cyc);
            if (!e.fill) begin
                exp_ov  = 1'b1;
                exp_err = e.err;
                last_d  = e.d;
                last_dk = e.k;
            end
            last_pkt = e.pkt;
        end
        check_val("OUT_VALID", 32'(OUT_VALID), 32'(exp_ov));
        check_val("D",         32'(D),         32'(last_d));
        check_val("DK",        32'(DK),        32'(last_dk));
        check_val("FRAME_ERR", 32'(FRAME_ERR), 32'(exp_err));
        check_val("IN_PKT",    32'(IN_PKT),    32'(last_pkt));
        check_val("IN_READY",  32'(IN_READY),  32'(!(last_start > cyc + 1)));
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step(output bit acc);
        acc = IN_VALID && IN_READY;
        @(posedge CLK);
        cyc++;
        if (acc) schedule(LANE_DATA, LANE_K);
        #1;
        check_cycle();
        @(negedge CLK);
    endtask

    task automatic send_word(input logic [8*LANES-1:0] data, input logic [LANES-1:0] k);
        bit acc;
        int n;
        IN_VALID  = 1'b1;
        LANE_DATA = data;
        LANE_K    = k;
        n = 0;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check_val("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        IN_VALID = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic rand_lane(output logic [7:0] b, output logic k);
        int r;
        r = int'($urandom_range(0, 15));
        k = 1'b1;
        case (r)
            6:  b = 8'hFB;
            7:  b = 8'h5C;
            8:  b = 8'hFD;
            9:  b = 8'hFE;
            10: b = 8'h1C;
            11: b = 8'h7C;
            12: b = 8'hBC;
            13: b = 8'($urandom);
            default: begin
                b = 8'($urandom);
                k = 1'b0;
            end
        endcase
    endtask

    task automatic rand_word(output logic [8*LANES-1:0] data, output logic [LANES-1:0] k);
        logic [7:0] b;
        logic       kk;
        for (int l = 0; l < LANES; l++) begin
            rand_lane(b, kk);
            data[8*l +: 8] = b;
            k[l]           = kk;
        end
        // Bias toward well-formed packets now and then
        if ($urandom_range(0, 3) == 0) begin
            data[7:0] = 8'hFB;
            k[0]      = 1'b1;
            data[8*(LANES-1) +: 8] = 8'hFD;
            k[LANES-1] = 1'b1;
        end
    endtask

    initial begin
        bit acc;
        bit last_acc;
        logic [8*LANES-1:0] rd;
        logic [LANES-1:0]   rk;

        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        RESET_L      = 1'b0;
        IN_VALID     = 1'b0;
        LANE_DATA    = '0;
        LANE_K       = '0;
        model_reset();
        #1;
        check_cycle();
        @(negedge CLK);
        idle(2);
        RESET_L = 1'b1;
        idle(1);

        // 1: simple framed packet
        send_word(32'hFD2211FB, 4'b1001);
        idle(6);

        // 2: three words back to back
        send_word(32'h030201FB, 4'b0001);
        send_word(32'h07060504, 4'b0000);
        send_word(32'hFD0A0908, 4'b1000);
        idle(14);

        // 3: filler lanes dropped
        send_word(32'h337C1C44, 4'b0110);
        idle(6);

        // 4: STP misplaced on lane 2
        send_word(32'h05FBBCBC, 4'b0111);
        idle(6);

        // 5: END on lane 1 inside packet, then END in IDLE
        send_word(32'h2211FDBC, 4'b0011);
        idle(6);
        send_word(32'hBCBCBCFD, 4'b1111);
        idle(6);

        // 6: reset while lane 1 on D with a held word
        send_word(32'hFD2211FB, 4'b1001);
        send_word(32'h44332211, 4'b0000);
        IN_VALID = 1'b0;
        step(acc);
        RESET_L = 1'b0;
        #1;
        check_val("rst_OUT_VALID", 32'(OUT_VALID), 32'd0);
        check_val("rst_D",         32'(D),         32'd0);
        check_val("rst_IN_PKT",    32'(IN_PKT),    32'd0);
        check_val("rst_IN_READY",  32'(IN_READY),  32'd1);
        model_reset();
        check_cycle();
        @(negedge CLK);
        idle(2);
        RESET_L = 1'b1;
        idle(1);
        send_word(32'hFD6655FB, 4'b1001);
        idle(8);

        // Randomized traffic with a randomly stalling source
        last_acc = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!IN_VALID || last_acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    rand_word(rd, rk);
                    IN_VALID  = 1'b1;
                    LANE_DATA = rd;
                    LANE_K    = rk;
                end else begin
                    IN_VALID = 1'b0;
                end
            end
            step(acc);
            last_acc = acc;
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
